stack_param: RTL



---
 rtl/stack_param_if.sv | 35 +++
 rtl/stack_param.sv | 131 +++++++++++++
 2 files changed

// File: rtl/stack_param_if.sv
// rtl/stack_param_if.sv - command/result bundle for the stack_param LIFO
//
// Purpose: groups the stack command inputs and the result/status outputs so
// the sequencer (master) and the stack (slave) share one typed connection.
//
// Signals:
//   command  in   2      0 = NOP, 1 = PUSH, 2 = POP, 3 = PEEK
//   index    in   IDX_W  PEEK depth, 0 = top of stack
//   i_data   in   WIDTH  PUSH data
//   o_data   out  WIDTH  result of the last successful POP/PEEK (holds otherwise)
//   o_valid  out  1      one-cycle pulse: new data on o_data
//   count    out  CNT_W  number of valid entries
//   full     out  1      count == DEPTH
//   empty    out  1      count == 0
//   error    out  1      one-cycle pulse: illegal command
interface stack_param_if #(
   parameter int WIDTH = 4,
   parameter int IDX_W = 3,
   parameter int CNT_W = 3
);
   logic [1:0]       command;
   logic [IDX_W-1:0] index;
   logic [WIDTH-1:0] i_data;
   logic [WIDTH-1:0] o_data;
   logic             o_valid;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             error;

   modport master (output command, index, i_data,
                   input  o_data, o_valid, count, full, empty, error);
   modport slave  (input  command, index, i_data,
                   output o_data, o_valid, count, full, empty, error);
endinterface

// File: rtl/stack_param.sv
// rtl/stack_param.sv - parametrised LIFO stack with push/pop/indexed peek
//
// Purpose: bounded operand stack executing one command per cycle. The top
// pointer walks a circular buffer so a full-stack push can either overwrite
// the oldest entry (OVERWRITE = 1) or be rejected with an error pulse.
//
// Ports:
//   clk_i   in   clock, all state updates on the rising edge
//   rst_i   in   asynchronous active-high reset, clears all state
//   sp_if   slave side of stack_param_if (command/index/i_data in,
//           o_data/o_valid/count/full/empty/error out)
module stack_param #(
   parameter int WIDTH     = 4,
   parameter int DEPTH     = 5,
   parameter int IDX_W     = 3,
   parameter int OVERWRITE = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   stack_param_if.slave sp_if
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   // Pointer intermediates carry two spare bits so top + DEPTH never wraps.
   localparam int PW    = IDX_W + 2;

   localparam logic [1:0]       CMD_PUSH = 2'd1;
   localparam logic [1:0]       CMD_POP  = 2'd2;
   localparam logic [1:0]       CMD_PEEK = 2'd3;
   localparam logic [IDX_W-1:0] TOP_LAST = IDX_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [IDX_W-1:0] top_q, top_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] o_data_q, o_data_d;
   logic             o_valid_q, o_valid_d;
   logic             error_q, error_d;

   logic             wr_en;
   logic             full, empty, peek_ok;
   logic [IDX_W-1:0] top_inc, top_dec, peek_addr;
   logic [PW-1:0]    peek_sum;

   assign full    = (count_q == CNT_FULL);
   assign empty   = (count_q == '0);
   assign top_inc = (top_q == TOP_LAST) ? '0 : IDX_W'(PW'(top_q) + PW'(1));
   assign top_dec = (top_q == '0) ? TOP_LAST : IDX_W'(PW'(top_q) - PW'(1));

   // Entry INDEX below the top lives at (top - INDEX) mod DEPTH; adding DEPTH
   // first keeps the subtraction non-negative for every legal INDEX.
   always_comb begin
      peek_sum = PW'(top_q) + PW'(DEPTH) - PW'(sp_if.index);
      if (peek_sum >= PW'(DEPTH)) begin
         peek_sum = peek_sum - PW'(DEPTH);
      end
   end
   assign peek_addr = IDX_W'(peek_sum);
   assign peek_ok   = (PW'(sp_if.index) < PW'(count_q));

   always_comb begin
      top_d     = top_q;
      count_d   = count_q;
      o_data_d  = o_data_q;
      o_valid_d = 1'b0;
      error_d   = 1'b0;
      wr_en     = 1'b0;
      case (sp_if.command)
         CMD_PUSH: begin
            if (!full) begin
               wr_en   = 1'b1;
               top_d   = top_inc;
               count_d = count_q + 1'b1;
            end else if (OVERWRITE != 0) begin
               // Circular buffer: the slot after top holds the oldest entry.
               wr_en = 1'b1;
               top_d = top_inc;
            end else begin
               error_d = 1'b1;
            end
         end
         CMD_POP: begin
            if (!empty) begin
               o_data_d  = mem_q[top_q];
               o_valid_d = 1'b1;
               top_d     = top_dec;
               count_d   = count_q - 1'b1;
            end else begin
               error_d = 1'b1;
            end
         end
         CMD_PEEK: begin
            if (peek_ok) begin
               o_data_d  = mem_q[peek_addr];
               o_valid_d = 1'b1;
            end else begin
               error_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         top_q     <= TOP_LAST;
         count_q   <= '0;
         o_data_q  <= '0;
         o_valid_q <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         if (wr_en) begin
            mem_q[top_inc] <= sp_if.i_data;
         end
         top_q     <= top_d;
         count_q   <= count_d;
         o_data_q  <= o_data_d;
         o_valid_q <= o_valid_d;
         error_q   <= error_d;
      end
   end

   assign sp_if.o_data  = o_data_q;
   assign sp_if.o_valid = o_valid_q;
   assign sp_if.error   = error_q;
   assign sp_if.count   = count_q;
   assign sp_if.full    = full;
   assign sp_if.empty   = empty;
endmodule
